// File: rtl/alu_exec_unit.sv
// Registered execute stage: single-cycle add-family ops with C/Z/N/V flag register,
// plus an iterative shift-add multiply behind a valid/ready handshake.
module alu_exec_unit #(
    parameter int         WIDTH      = 16,
    parameter logic [4:0] MUL_OPCODE = 5'b00010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [1:0]       ALU_op,
    input  logic             Sub,
    input  logic             Cin_en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam logic [4:0] CMP_OPCODE = 5'b00110;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t           state_q;
    logic             out_valid_q;
    logic             wr_en_q;
    logic [WIDTH-1:0] result_q;
    logic             c_q, z_q, n_q, v_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    count_q;

    logic [WIDTH-1:0] bx_d;
    logic             cin_d;
    logic [WIDTH:0]   sum_d;
    logic             ovf_d;
    logic [WIDTH-1:0] acc_d;

    // ALU_op is decoded upstream into Sub/Cin_en; kept on the port for compatibility
    logic unused_alu_op;
    assign unused_alu_op = ^ALU_op;

    always_comb begin
        bx_d  = Sub ? ~B : B;
        cin_d = Cin_en ? c_q : Sub;
        sum_d = {1'b0, A} + {1'b0, bx_d} + {{WIDTH{1'b0}}, cin_d};
        ovf_d = (A[WIDTH-1] == bx_d[WIDTH-1]) && (sum_d[WIDTH-1] != A[WIDTH-1]);
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            result_q    <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (opcode == MUL_OPCODE) begin
                            mcand_q  <= A;
                            mplier_q <= B;
                            acc_q    <= '0;
                            count_q  <= '0;
                            state_q  <= ST_MUL;
                        end else begin
                            result_q    <= sum_d[WIDTH-1:0];
                            out_valid_q <= 1'b1;
                            wr_en_q     <= (opcode != CMP_OPCODE);
                            c_q         <= sum_d[WIDTH];
                            z_q         <= (sum_d[WIDTH-1:0] == '0);
                            n_q         <= sum_d[WIDTH-1];
                            v_q         <= ovf_d;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                    // Result is taken on the final iteration so out_valid lands 17 cycles after accept
                    if (count_q == CW'(WIDTH - 1)) begin
                        result_q    <= acc_d;
                        out_valid_q <= 1'b1;
                        wr_en_q     <= 1'b1;
                        z_q         <= (acc_d == '0);
                        n_q         <= acc_d[WIDTH-1];
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign wr_en     = wr_en_q;
    assign result    = result_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_v    = v_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, multiply/handshake/reset sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [1:0]  ALU_op;
    logic        Sub;
    logic        Cin_en;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic [15:0] result;
    logic        wr_en;
    logic        flag_c, flag_z, flag_n, flag_v;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic        m_c, m_z, m_n, m_v;
    logic [15:0] m_res;
    logic        m_wr;

    alu_exec_unit #(.WIDTH(16), .MUL_OPCODE(5'b00010)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .ALU_op(ALU_op), .Sub(Sub), .Cin_en(Cin_en),
        .A(A), .B(B), .out_valid(out_valid), .result(result), .wr_en(wr_en),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic        sub;
        logic        cen;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  cznv;
        logic        wr;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic sub, input logic cen,
                         input logic [15:0] a, input logic [15:0] b, input logic v);
        opcode = op; Sub = sub; Cin_en = cen; A = a; B = b; in_valid = v;
        ALU_op = 2'($urandom_range(0, 3));
    endtask

    // Model works on integers: unsigned sum for carry, signed range for overflow.
    task automatic model_exec(input logic [4:0] op, input logic sub, input logic cen,
                              input logic [15:0] a, input logic [15:0] b);
        logic [15:0] bx;
        int unsigned cin, usum;
        int ssum;
        if (op == 5'b00010) begin
            m_res = 16'((int'(a) * int'(b)) & 32'hFFFF);
            m_wr  = 1'b1;
            m_z   = (m_res == 16'd0);
            m_n   = m_res[15];
        end else begin
            bx   = sub ? ~b : b;
            cin  = cen ? int'(m_c) : int'(sub);
            usum = int'(a) + int'(bx) + cin;
            ssum = int'($signed(a)) + int'($signed(bx)) + int'(cin);
            m_res = 16'(usum & 32'hFFFF);
            m_c   = (usum > 32'hFFFF);
            m_z   = (m_res == 16'd0);
            m_n   = m_res[15];
            m_v   = (ssum > 32767) || (ssum < -32768);
            m_wr  = (op != 5'b00110);
        end
    endtask

    task automatic check_out(input string nm);
        chk({nm, "_result"}, 32'(result), 32'(m_res));
        chk({nm, "_wr_en"}, 32'(wr_en), 32'(m_wr));
        chk({nm, "_flags"}, 32'({flag_c, flag_z, flag_n, flag_v}), 32'({m_c, m_z, m_n, m_v}));
    endtask

    initial begin
        int lat;
        logic [4:0] op;
        logic is_mul;
        logic out_seen;

        tbl[0] = '{5'b00000, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 1'b1};
        tbl[1] = '{5'b00000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 1'b1};
        tbl[2] = '{5'b00001, 1'b1, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 4'b0010, 1'b1};
        tbl[3] = '{5'b00110, 1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 4'b1001, 1'b0};
        tbl[4] = '{5'b00001, 1'b1, 1'b1, 16'h0005, 16'h0005, 16'h0000, 4'b1100, 1'b1};
        tbl[5] = '{5'b00000, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 1'b1};
        tbl[6] = '{5'b00000, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1'b1};

        // Reset state
        rst = 1'b1;
        drive(5'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        m_c = 0; m_z = 0; m_n = 0; m_v = 0; m_res = 0; m_wr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);

        // Directed table, issued back-to-back so each op sees the previous flags
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].sub, tbl[i].cen, tbl[i].a, tbl[i].b, 1'b1);
            model_exec(tbl[i].op, tbl[i].sub, tbl[i].cen, tbl[i].a, tbl[i].b);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d_result", i), 32'(result), 32'(tbl[i].res));
            chk($sformatf("tbl%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].wr));
            chk($sformatf("tbl%0d_flags", i), 32'({flag_c, flag_z, flag_n, flag_v}), 32'(tbl[i].cznv));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_wr_en", 32'(wr_en), 32'd0);
        chk("idle_result_hold", 32'(result), 32'h0002);

        // MUL with C=1,V=1 preset via CMP; an ADD held on in_valid during the multiply
        drive(5'b00110, 1'b1, 1'b0, 16'h8000, 16'h0001, 1'b1);
        model_exec(5'b00110, 1'b1, 1'b0, 16'h8000, 16'h0001);
        @(posedge clk);
        #1;
        drive(5'b00010, 1'b0, 1'b0, 16'h0123, 16'h0045, 1'b1);
        model_exec(5'b00010, 1'b0, 1'b0, 16'h0123, 16'h0045);
        @(posedge clk);
        #1;
        drive(5'b00000, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b1);
        lat = 1;
        out_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) out_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("mul_ready_low_16", 32'(out_seen), 32'd0);
        chk("mul_latency", 32'(lat), 32'd17);
        chk("mul_result_4e6f", 32'(result), 32'h4E6F);
        check_out("mul");
        chk("mul_ready_after", 32'(in_ready), 32'd1);
        model_exec(5'b00000, 1'b0, 1'b0, 16'h1111, 16'h2222);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_out_valid", 32'(out_valid), 32'd1);
        chk("b2b_result", 32'(result), 32'h3333);
        check_out("b2b");

        // Randomized ops against the model
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 7))
                0: op = 5'b00010;
                1: op = 5'b00110;
                default: begin
                    op = 5'($urandom_range(0, 31));
                    if (op == 5'b00010 || op == 5'b00110) op = 5'b00000;
                end
            endcase
            is_mul = (op == 5'b00010);
            drive(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom), 1'b1);
            if (!in_ready) chk($sformatf("rnd%0d_ready", n), 32'(in_ready), 32'd1);
            model_exec(op, Sub, Cin_en, A, B);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("rnd%0d_latency", n), 32'(lat), is_mul ? 32'd17 : 32'd1);
            check_out($sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset mid-MUL aborts the multiply and clears flags
        drive(5'b00110, 1'b1, 1'b0, 16'h8000, 16'h0001, 1'b1);
        @(posedge clk);
        #1;
        drive(5'b00010, 1'b0, 1'b0, 16'h00FF, 16'h00FF, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midmul_rst_flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
        chk("midmul_rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midmul_ready_after_rst", 32'(in_ready), 32'd1);
        out_seen = 1'b0;
        repeat (20) begin
            if (out_valid) out_seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("midmul_no_out_valid", 32'(out_seen), 32'd0);
        chk("midmul_flags_hold", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
